// File: rtl/mda_rx_timing.sv
// MDA video input analyzer: measures line/frame timing, declares lock; MDA_RX_PIXCAP_EN adds a lit-pixel count.
// Latency: pin edge sampled at posedge N updates measurement registers at posedge N+3.
// Backpressure: none; pins are free-running and results are simply overwritten each frame.
module mda_rx_timing #(
    parameter logic [31:0] NCO_INC     = 32'd1396465667,
    parameter int          EXP_HPERIOD = 2713,
    parameter int          EXP_LINES   = 370,
    parameter int          H_TOL       = 8,
    parameter int          TIMEOUT     = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pin_v,
    input  logic        pin_hsync,
    input  logic        pin_vsync,
    output logic [15:0] hperiod,
    output logic [15:0] hwidth,
    output logic [9:0]  lines,
    output logic [9:0]  vwidth,
    output logic [19:0] lit_count,
    output logic        frame_stb,
    output logic        locked,
    output logic        lost
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    // two synchronizer stages, one retime stage, one history stage
    logic [3:0] hs_q, vs_q;
    logic       hrise, hfall, vrise, vfall;

    logic [15:0] hcnt_q, hcnt_d, hper_q, hper_d, hwid_q, hwid_d;
    logic [9:0]  lcnt_q, lcnt_d, vwid_q, vwid_d;
    logic [15:0] hdiff;
    logic        frame_good;

    state_t              state_q, state_d;
    logic [1:0]          good_q, good_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                lost_q, lost_d;
    logic                latch;

    logic [15:0] hperiod_q;
    logic [15:0] hwidth_q;
    logic [9:0]  lines_q, vwidth_q;
    logic        stb_q;

    assign hrise = hs_q[2] & ~hs_q[3];
    assign hfall = ~hs_q[2] & hs_q[3];
    assign vrise = vs_q[2] & ~vs_q[3];
    assign vfall = ~vs_q[2] & vs_q[3];

    always_comb begin
        hcnt_d = hcnt_q;
        if (hrise)
            hcnt_d = 16'd1;
        else if (hcnt_q != 16'hFFFF)
            hcnt_d = hcnt_q + 16'd1;

        hper_d = hrise ? hcnt_q : hper_q;
        hwid_d = hfall ? hcnt_q : hwid_q;

        // a line starting on the frame edge belongs to the new frame
        lcnt_d = lcnt_q;
        if (vrise)
            lcnt_d = hrise ? 10'd1 : 10'd0;
        else if (hrise && lcnt_q != 10'h3FF)
            lcnt_d = lcnt_q + 10'd1;

        vwid_d = vfall ? lcnt_q : vwid_q;
    end

    assign hdiff = (hper_q >= 16'(EXP_HPERIOD)) ? (hper_q - 16'(EXP_HPERIOD))
                                                : (16'(EXP_HPERIOD) - hper_q);
    assign frame_good = (hdiff <= 16'(H_TOL)) && (lcnt_q == 10'(EXP_LINES));

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        lost_d  = lost_q;
        tcnt_d  = tcnt_q + TCNT_W'(1);
        latch   = 1'b0;
        if (vrise) begin
            tcnt_d = '0;
            lost_d = 1'b0;
            case (state_q)
                SEARCH: state_d = CHECK;
                CHECK: begin
                    latch = 1'b1;
                    if (frame_good) begin
                        good_d = good_q + 2'd1;
                        if (good_q == 2'd1)
                            state_d = LOCKED;
                    end else begin
                        good_d = 2'd0;
                    end
                end
                LOCKED: begin
                    latch = 1'b1;
                    if (!frame_good) begin
                        state_d = CHECK;
                        good_d  = 2'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            state_d = SEARCH;
            good_d  = 2'd0;
            lost_d  = 1'b1;
            tcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= '0;
            vs_q      <= '0;
            hcnt_q    <= '0;
            hper_q    <= '0;
            hwid_q    <= '0;
            lcnt_q    <= '0;
            vwid_q    <= '0;
            state_q   <= SEARCH;
            good_q    <= '0;
            tcnt_q    <= '0;
            lost_q    <= 1'b0;
            hperiod_q <= '0;
            hwidth_q  <= '0;
            lines_q   <= '0;
            vwidth_q  <= '0;
            stb_q     <= 1'b0;
        end else begin
            hs_q    <= {hs_q[2:0], pin_hsync};
            vs_q    <= {vs_q[2:0], pin_vsync};
            hcnt_q  <= hcnt_d;
            hper_q  <= hper_d;
            hwid_q  <= hwid_d;
            lcnt_q  <= lcnt_d;
            vwid_q  <= vwid_d;
            state_q <= state_d;
            good_q  <= good_d;
            tcnt_q  <= tcnt_d;
            lost_q  <= lost_d;
            stb_q   <= latch;
            if (latch) begin
                hperiod_q <= hper_q;
                hwidth_q  <= hwid_q;
                lines_q   <= lcnt_q;
                vwidth_q  <= vwid_q;
            end
        end
    end

`ifdef MDA_RX_PIXCAP_EN
    logic [2:0]  v_q;
    logic [31:0] phase_q, phase_d;
    logic [32:0] phase_sum;
    logic        pix;
    logic [19:0] acc_q, acc_d, lit_q;

    // NCO carry is the pixel strobe; phase restarts at each line
    assign phase_sum = {1'b0, phase_q} + {1'b0, NCO_INC};
    assign pix       = phase_sum[32] & v_q[2];

    always_comb begin
        phase_d = hrise ? 32'd0 : phase_sum[31:0];
        acc_d   = acc_q;
        if (vrise)
            acc_d = pix ? 20'd1 : 20'd0;
        else if (pix && acc_q != 20'hFFFFF)
            acc_d = acc_q + 20'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            lit_q   <= '0;
        end else begin
            v_q     <= {v_q[1:0], pin_v};
            phase_q <= phase_d;
            acc_q   <= acc_d;
            if (latch)
                lit_q <= acc_q;
        end
    end

    assign lit_count = lit_q;
`else
    logic unused_pixcap;
    assign unused_pixcap = ^{pin_v, NCO_INC};
    assign lit_count     = '0;
`endif

    assign hperiod   = hperiod_q;
    assign hwidth    = hwidth_q;
    assign lines     = lines_q;
    assign vwidth    = vwidth_q;
    assign frame_stb = stb_q;
    assign locked    = (state_q == LOCKED);
    assign lost      = lost_q;

endmodule

// File: tb/tb_mda_rx_timing.sv
// Bench for mda_rx_timing: scaled-down frame timing, frame-level reference model.
// Latency: checks taken 4 bench steps after the driven vsync rise; backpressure: n/a.
module tb_mda_rx_timing;

    localparam int    P   = 100;
    localparam int    L   = 12;
    localparam int    TOL = 8;
    localparam int    TO  = 5000;
    localparam int    HW  = 30;
    localparam int    VW  = 4;
    localparam longint INC = 64'd1396465667;

    logic        clk = 1'b0;
    logic        rst_n, pin_v, pin_hsync, pin_vsync;
    logic [15:0] hperiod, hwidth;
    logic [9:0]  lines, vwidth;
    logic [19:0] lit_count;
    logic        frame_stb, locked, lost;

    always #10 clk = ~clk;

    mda_rx_timing #(
        .EXP_HPERIOD(P), .EXP_LINES(L), .H_TOL(TOL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_v(pin_v), .pin_hsync(pin_hsync),
        .pin_vsync(pin_vsync), .hperiod(hperiod), .hwidth(hwidth),
        .lines(lines), .vwidth(vwidth), .lit_count(lit_count),
        .frame_stb(frame_stb), .locked(locked), .lost(lost)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int vs_cyc = 0;

    // frame-level model
    bit m_seen = 0;
    int m_run = 0;
    bit m_lost = 0;
    int exp_hper = 0, exp_hwid = 0, exp_lines = 0, exp_vwid = 0, exp_lit = 0;
    bit exp_lit_ok = 1;
    int pf_p = 0, pf_l = 0, pf_hw = 0, pf_vw = 0, pf_lit = 0;
    bit pf_lit_ok = 0;
    int last_p = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int carries(input int n);
        return int'((longint'(n) * INC) >> 32);
    endfunction

    task automatic chk_zero(input string pfx);
        chk({pfx, " hperiod"}, hperiod, 0);
        chk({pfx, " hwidth"}, hwidth, 0);
        chk({pfx, " lines"}, lines, 0);
        chk({pfx, " vwidth"}, vwidth, 0);
        chk({pfx, " lit_count"}, lit_count, 0);
        chk({pfx, " frame_stb"}, frame_stb, 0);
        chk({pfx, " locked"}, locked, 0);
        chk({pfx, " lost"}, lost, 0);
    endtask

    task automatic model_reset();
        m_seen = 0; m_run = 0; m_lost = 0;
        exp_hper = 0; exp_hwid = 0; exp_lines = 0; exp_vwid = 0;
        exp_lit = 0; exp_lit_ok = 1; last_p = 0;
    endtask

    // One frame: vsync and hsync rise together, then l lines of period p.
    task automatic frame(input int p, input int l, input int hw, input int vw, input int rst_line);
        bit stb_exp;
        bit good;
        int d;
        int k;
        stb_exp = 0;
        if (m_seen) begin
            stb_exp = 1;
            d = pf_p - P;
            if (d < 0) d = -d;
            good = (d <= TOL) && (pf_l == L);
            m_run = good ? m_run + 1 : 0;
            exp_hper = pf_p; exp_hwid = pf_hw; exp_lines = pf_l; exp_vwid = pf_vw;
            exp_lit = pf_lit; exp_lit_ok = pf_lit_ok;
        end
        m_seen = 1;
        m_lost = 0;
        pf_p = p; pf_l = l; pf_hw = hw; pf_vw = vw;
        pf_lit_ok = (last_p != 0);
        pf_lit = (carries(last_p) - carries(last_p - 1))
               + (l - 1) * (carries(p) - carries(p - 1)) + l * carries(p - 1);
        for (int ln = 0; ln < l; ln++) begin
            for (int t = 0; t < p; t++) begin
                k = ln * p + t;
                step();
                if (k == 0) vs_cyc = cyc;
                if (k == 3 || k == 5) chk("frame_stb quiet", frame_stb, 0);
                if (k == 4) begin
                    chk("frame_stb", frame_stb, stb_exp);
                    chk("locked", locked, (m_run >= 2));
                    chk("lost", lost, m_lost);
                    chk("hperiod", hperiod, exp_hper);
                    chk("hwidth", hwidth, exp_hwid);
                    chk("lines", lines, exp_lines);
                    chk("vwidth", vwidth, exp_vwid);
`ifdef MDA_RX_PIXCAP_EN
                    if (exp_lit_ok) chk("lit_count", lit_count, exp_lit);
`else
                    chk("lit_count", lit_count, 0);
`endif
                end
                pin_hsync = (t < hw);
                pin_vsync = (ln < vw - 1) || (ln == vw - 1 && t < 60);
                if (ln == rst_line && t == p / 2) begin
                    #3 rst_n = 1'b0;
                    #2 chk_zero("async reset");
                    model_reset();
                    #5 rst_n = 1'b1;
                    return;
                end
            end
        end
        last_p = p;
    endtask

    task automatic idle(input int n);
        int d;
        pin_hsync = 1'b0;
        pin_vsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            d = cyc - vs_cyc;
            if (d == 4 + TO - 1) begin
                chk("lost before timeout", lost, 0);
                chk("locked before timeout", locked, (m_run >= 2));
            end
            if (d == 4 + TO) begin
                chk("lost at timeout", lost, 1);
                chk("locked at timeout", locked, 0);
                m_lost = 1; m_seen = 0; m_run = 0;
            end
        end
        last_p = 0;
    endtask

    task automatic rand_frame();
        int p, l;
        p = P - 12 + int'($urandom_range(0, 24));
        l = ($urandom_range(0, 3) == 0) ? L - 1 + int'($urandom_range(0, 2)) : L;
        frame(p, l, int'($urandom_range(5, 40)), int'($urandom_range(2, 5)), -1);
    endtask

    initial begin
        rst_n = 1'b0;
        pin_v = 1'b1;
        pin_hsync = 1'b0;
        pin_vsync = 1'b0;
        model_reset();
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        repeat (4) frame(P, L, HW, VW, -1);
        frame(P, L - 2, HW, VW, -1);
        repeat (3) frame(P, L, HW, VW, -1);
        frame(P + 9, L, HW, VW, -1);
        repeat (3) frame(P, L, HW, VW, -1);
        frame(P + 8, L, HW, VW, -1);
        frame(P - 8, L, HW, VW, -1);
        frame(P - 9, L, HW, VW, -1);
        repeat (12) rand_frame();

        repeat (3) frame(P, L, HW, VW, -1);
        idle(TO + 10);
        repeat (4) frame(P, L, HW, VW, -1);

        frame(P, L, HW, VW, 8);
        repeat (4) frame(P, L, HW, VW, -1);
        repeat (6) rand_frame();
        frame(P, L, HW, VW, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
